// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types: FSM state encoding, latch index map and
// register-number type used by the hazard logic.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    // Bit positions of each inter-stage latch in latch_w / latch_rst
    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load in EX has not produced yet. r0 is hardwired, so it never hazards.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_memread,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     hazard
);

    // Pure compare; no state
    always_comb begin
        hazard = ex_memread && (ex_wsel != 5'd0) &&
                 ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall sequencer for the 5-stage pipeline.
// Optional build macro PIPE_PERF_EN enables the stall/flush perf counters;
// without it the counter ports are tied to zero.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DWAIT_MAX = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dreq,
    input  logic             mem_halt,
    input  logic             br_taken,
    input  logic             ex_memread,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    output logic [3:0]       latch_w,
    output logic [3:0]       latch_rst,
    output logic             pc_en,
    output logic             halt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WD_W = (DWAIT_MAX > 1) ? $clog2(DWAIT_MAX + 1) : 1;

    pipe_state_t     state_q, state_d;
    logic            halt_q, halt_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    logic       hazard;
    logic       dmiss;
    logic       rules_active;
    logic [3:0] rule_w, rule_rst;
    logic       rule_pc;

    load_use_detect u_lud (
        .ex_memread (ex_memread),
        .ex_wsel    (ex_wsel),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .hazard     (hazard)
    );

    assign dmiss = mem_dreq && !dhit;

    // Rules 2-6 in priority order; shared by RUN and the DWAIT release cycle
    always_comb begin
        rule_w   = 4'hF;
        rule_rst = 4'h0;
        rule_pc  = 1'b1;
        if (mem_halt) begin
            rule_w   = 4'b1000;
            rule_rst = 4'b0111;
            rule_pc  = 1'b0;
        end else if (br_taken) begin
            // Branch squashes younger stages, including any load-use victim
            rule_w   = 4'b1000;
            rule_rst = 4'b0111;
            rule_pc  = 1'b1;
        end else if (hazard) begin
            rule_w   = 4'b1100;
            rule_rst = 4'b0010;
            rule_pc  = 1'b0;
        end else if (!ihit) begin
            rule_w   = 4'b1110;
            rule_rst = 4'b0001;
            rule_pc  = 1'b0;
        end
    end

    // Rules apply in RUN without a pending miss, or on the cycle DWAIT sees dhit
    assign rules_active = !RST && (((state_q == RUN) && !dmiss) ||
                                   ((state_q == DWAIT) && dhit));

    // Next-state, outputs, watchdog and sticky flags
    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        err_d     = err_q;
        wd_cnt_d  = wd_cnt_q;
        latch_w   = 4'h0;
        latch_rst = 4'h0;
        pc_en     = 1'b0;
        if (RST) begin
            state_d   = RUN;
            halt_d    = 1'b0;
            err_d     = 1'b0;
            wd_cnt_d  = '0;
            latch_rst = 4'hF;
        end else if (rules_active) begin
            latch_w   = rule_w;
            latch_rst = rule_rst;
            pc_en     = rule_pc;
            state_d   = mem_halt ? HALTED : RUN;
            halt_d    = mem_halt;
        end else if (state_q == RUN) begin
            // Miss in RUN: freeze everything and wait for the data side
            state_d  = DWAIT;
            wd_cnt_d = '0;
        end else if (state_q == DWAIT) begin
            // Still waiting: count toward the watchdog, stay frozen
            if (DWAIT_MAX != 0) begin
                if (wd_cnt_q == WD_W'(DWAIT_MAX - 1))
                    err_d = 1'b1;
                if (wd_cnt_q != WD_W'(DWAIT_MAX))
                    wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    // State and flag registers
    always_ff @(posedge CLK) begin
        state_q  <= state_d;
        halt_q   <= halt_d;
        err_q    <= err_d;
        wd_cnt_q <= wd_cnt_d;
    end

    assign halt_o = halt_q;
    assign err_o  = err_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_ev, flush_ev;

    assign stall_ev = !RST && (state_q != HALTED) && !pc_en;
    assign flush_ev = rules_active && !mem_halt && br_taken;

    // Saturating perf counters, cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with DWAIT_MAX=4. Inputs change on the
// falling edge; combinational outputs are checked 1ns later, registered
// outputs after the following rising edge.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, mem_dreq, mem_halt, br_taken, ex_memread;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic [3:0]  latch_w, latch_rst;
    logic        pc_en, halt_o, err_o;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(32), .DWAIT_MAX(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .mem_dreq   (mem_dreq),
        .mem_halt   (mem_halt),
        .br_taken   (br_taken),
        .ex_memread (ex_memread),
        .ex_wsel    (ex_wsel),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .latch_w    (latch_w),
        .latch_rst  (latch_rst),
        .pc_en      (pc_en),
        .halt_o     (halt_o),
        .err_o      (err_o),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] w, input logic [3:0] r, input logic pc);
        check({tag, ".w"}, 32'(latch_w), 32'(w));
        check({tag, ".rst"}, 32'(latch_rst), 32'(r));
        check({tag, ".pc"}, 32'(pc_en), 32'(pc));
        $display("step %s: w=%b rst=%b pc_en=%b halt=%b err=%b", tag, latch_w, latch_rst, pc_en, halt_o, err_o);
    endtask

    // Advance to the next falling edge (one rising edge passes)
    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; mem_halt = 1'b0;
        br_taken = 1'b0; ex_memread = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        next_cycle(); #1;
        chk_out("reset", 4'h0, 4'hF, 1'b0);
        next_cycle(); #1;
        check("reset.halt", 32'(halt_o), 32'd0);
        check("reset.err", 32'(err_o), 32'd0);
        check("reset.stall_cnt", stall_cnt, 32'd0);
        check("reset.flush_cnt", flush_cnt, 32'd0);

        // Test 1: reset while in DWAIT
        next_cycle(); RST = 1'b0; #1;
        chk_out("t1.run", 4'hF, 4'h0, 1'b1);
        next_cycle(); mem_dreq = 1'b1; #1;
        chk_out("t1.miss", 4'h0, 4'h0, 1'b0);
        next_cycle(); #1;
        chk_out("t1.dwait", 4'h0, 4'h0, 1'b0);
        next_cycle(); RST = 1'b1; #1;
        chk_out("t1.rst_mid", 4'h0, 4'hF, 1'b0);
        next_cycle(); RST = 1'b0; mem_dreq = 1'b0; #1;
        chk_out("t1.after", 4'hF, 4'h0, 1'b1);
        check("t1.err", 32'(err_o), 32'd0);
        check("t1.halt", 32'(halt_o), 32'd0);

        // Test 2: load-use via rs and via rt
        next_cycle(); ex_memread = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5; #1;
        chk_out("t2.lu_rs", 4'b1100, 4'b0010, 1'b0);
        next_cycle(); ex_wsel = 5'd7; id_rs = 5'd1; id_rt = 5'd7; #1;
        chk_out("t2.lu_rt", 4'b1100, 4'b0010, 1'b0);
        next_cycle(); idle_inputs(); #1;
        chk_out("t2.clear", 4'hF, 4'h0, 1'b1);

        // Test 3: dmem miss for 3 cycles, then hit
        next_cycle(); mem_dreq = 1'b1; #1;
        chk_out("t3.miss0", 4'h0, 4'h0, 1'b0);
        next_cycle(); #1;
        chk_out("t3.miss1", 4'h0, 4'h0, 1'b0);
        next_cycle(); #1;
        chk_out("t3.miss2", 4'h0, 4'h0, 1'b0);
        next_cycle(); dhit = 1'b1; #1;
        chk_out("t3.hit", 4'hF, 4'h0, 1'b1);
        next_cycle(); idle_inputs(); #1;
        chk_out("t3.run", 4'hF, 4'h0, 1'b1);
        ihit = 1'b0; #1;
        chk_out("t3.imiss", 4'b1110, 4'b0001, 1'b0);

        // Test 4: branch beats load-use; flush counted when perf is built
        next_cycle(); idle_inputs();
        br_taken = 1'b1; ex_memread = 1'b1; ex_wsel = 5'd3; id_rt = 5'd3; #1;
        chk_out("t4.br_lu", 4'b1000, 4'b0111, 1'b1);
        next_cycle(); idle_inputs(); #1;
`ifdef PIPE_PERF_EN
        check("t4.flush_cnt", flush_cnt, 32'd1);
`else
        check("t4.flush_cnt", flush_cnt, 32'd0);
        check("t4.stall_cnt", stall_cnt, 32'd0);
`endif
        // Miss beats branch; branch applied on the dhit cycle
        mem_dreq = 1'b1; br_taken = 1'b1; #1;
        chk_out("t4.miss_br", 4'h0, 4'h0, 1'b0);
        next_cycle(); dhit = 1'b1; #1;
        chk_out("t4.hit_br", 4'b1000, 4'b0111, 1'b1);

        // Test 6: r0 never stalls; watchdog after 4 DWAIT cycles
        next_cycle(); idle_inputs(); ex_memread = 1'b1; #1;
        chk_out("t6.r0", 4'hF, 4'h0, 1'b1);
        next_cycle(); idle_inputs(); mem_dreq = 1'b1; #1;
        chk_out("t6.miss", 4'h0, 4'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); #1;
            check($sformatf("t6.err_dw%0d", i), 32'(err_o), 32'd0);
        end
        next_cycle(); #1;
        check("t6.err_set", 32'(err_o), 32'd1);
        chk_out("t6.still_dwait", 4'h0, 4'h0, 1'b0);
        next_cycle(); RST = 1'b1; #1;
        next_cycle(); RST = 1'b0; idle_inputs(); #1;
        check("t6.err_clr", 32'(err_o), 32'd0);

        // Test 5: HALT retires, everything frozen until reset
        mem_halt = 1'b1; #1;
        chk_out("t5.halt", 4'b1000, 4'b0111, 1'b0);
        check("t5.halt_not_yet", 32'(halt_o), 32'd0);
        next_cycle(); mem_halt = 1'b0; br_taken = 1'b1; #1;
        check("t5.halt_o", 32'(halt_o), 32'd1);
        chk_out("t5.halted_br", 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            chk_out($sformatf("t5.hold%0d", i), 4'h0, 4'h0, 1'b0);
        end
        next_cycle(); RST = 1'b1; #1;
        chk_out("t5.rst", 4'h0, 4'hF, 1'b0);
        next_cycle(); RST = 1'b0; idle_inputs(); #1;
        check("t5.halt_clr", 32'(halt_o), 32'd0);
        chk_out("t5.run", 4'hF, 4'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
